// File: rtl/adder_tree_avg_if.sv
// rtl/adder_tree_avg_if.sv - operand/result handshake bundle for adder_tree_avg
interface adder_tree_avg_if #(
    parameter int N = 8,
    parameter int M = 8
) ();
    logic [M*N-1:0] ops;
    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   res;
    logic           ovf;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output ops, mode, in_valid, out_ready,
        input  in_ready, res, ovf, out_valid
    );

    modport slave (
        input  ops, mode, in_valid, out_ready,
        output in_ready, res, ovf, out_valid
    );
endinterface

// File: rtl/adder_tree_avg.sv
// rtl/adder_tree_avg.sv - pipelined M-way adder tree with average/saturating-sum output
// Define ADDER_TREE_ROUND_EN for round-half-up in average mode; truncation otherwise.
module adder_tree_avg #(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int SHIFT = 3
) (
    input  logic            clk,
    input  logic            rst,
    adder_tree_avg_if.slave bus
);
    localparam int L   = $clog2(M);
    localparam int W   = N + L + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
`ifdef ADDER_TREE_ROUND_EN
    localparam logic [W-1:0] RND = (SHIFT > 0) ? (W'(1) << RSH) : '0;
`else
    localparam logic [W-1:0] RND = '0;
`endif
    localparam logic [W-1:0] MAXV = {{(W-N){1'b0}}, {N{1'b1}}};

    // Level 0 is the capture stage S0; level k holds M>>k partial sums.
    logic [W-1:0] sum_q [0:L][0:M-1];
    logic [W-1:0] sum_d [0:L][0:M-1];
    logic [L:0]   vld_q, vld_d;
    logic [L:0]   mode_q, mode_d;
    logic [N-1:0] res_q, res_d;
    logic         ovf_q, ovf_d;
    logic         out_valid_q, out_valid_d;
    logic         advance;
    logic [W-1:0] q;

    always_comb begin
        advance     = ~out_valid_q | bus.out_ready;
        sum_d       = sum_q;
        vld_d       = vld_q;
        mode_d      = mode_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        q = mode_q[L] ? sum_q[L][0] : ((sum_q[L][0] + RND) >> SHIFT);
        if (advance) begin
            vld_d[0]  = bus.in_valid;
            mode_d[0] = bus.mode;
            for (int i = 0; i < M; i++) begin
                sum_d[0][i] = {{(W-N){1'b0}}, bus.ops[i*N +: N]};
            end
            for (int k = 1; k <= L; k++) begin
                vld_d[k]  = vld_q[k-1];
                mode_d[k] = mode_q[k-1];
                for (int i = 0; i < M/2; i++) begin
                    if (i < (M >> k)) begin
                        sum_d[k][i] = sum_q[k-1][2*i] + sum_q[k-1][2*i+1];
                    end
                end
            end
            out_valid_d = vld_q[L];
            // Bubbles clear the result registers so a held-off output never shows stale data.
            if (vld_q[L]) begin
                ovf_d = (q > MAXV);
                res_d = (q > MAXV) ? {N{1'b1}} : q[N-1:0];
            end else begin
                ovf_d = 1'b0;
                res_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= L; k++) begin
                for (int i = 0; i < M; i++) begin
                    sum_q[k][i] <= '0;
                end
            end
            vld_q       <= '0;
            mode_q      <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            vld_q       <= vld_d;
            mode_q      <= mode_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.res       = res_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule
